sonar_event_scheduler: RTL and testbench

- Services comparator events from the 16 SonarOnChip channels without CPU polling.
- Detects rising edges on each channel's cmp output and arbitrates pending channels round-robin.
- Issues one read on the shared 16-bit channel-register bus per event and queues a tagged event word in an internal FIFO for the management SoC, raising irq_o while data is queued.
- Sits between the channel array and the Wishbone slave decode, which owns the channel bus when this block is idle.

---
 rtl/sonar_event_scheduler.sv | 195 +++++++++++++++++++
 tb/tb_sonar_event_scheduler.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sonar_event_scheduler.sv
// Event scheduler for the SonarOnChip channel array: catches comparator rising edges,
// reads one channel register per event round-robin and queues tagged words for the SoC.
module sonar_event_scheduler #(
    parameter int NCH     = 16,
    parameter int DW      = 16,
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 15
) (
    input  logic           wb_clk_i,
    input  logic           wb_rst_ni,
    input  logic           enable_i,
    input  logic           clear_i,
    input  logic           ce_pcm_i,
    input  logic [NCH-1:0] cmp_i,
    input  logic [3:0]     rd_adr_i,
    output logic [NCH-1:0] m_valid_o,
    output logic [3:0]     m_adr_o,
    output logic           m_strb_o,
    input  logic           m_ack_i,
    input  logic [DW-1:0]  m_dat_i,
    output logic           busy_o,
    input  logic           evt_pop_i,
    output logic           evt_valid_o,
    output logic [31:0]    evt_data_o,
    output logic [3:0]     evt_count_o,
    output logic           overflow_o,
    output logic           irq_o
);
    localparam int CW = $clog2(NCH);
    localparam int AW = $clog2(DEPTH);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, REQ, PUSH} state_t;
    state_t state, state_nx;

    logic [NCH-1:0] cmp_q, pending, rise, grant_mask;
    logic [CW-1:0]  rr, winner;
    logic           found;
    logic [10:0]    ts, ts_lat;
    logic [TW-1:0]  tcnt;
    logic           to_flag;
    logic [3:0]     ch_lat;
    logic [15:0]    dat_lat;
    logic           grant, take, expire, push, pop;

    logic [31:0]    mem [DEPTH];
    logic [AW-1:0]  wr_ptr, rd_ptr;
    logic [AW:0]    count;

    assign rise = cmp_i & ~cmp_q;

    // Round-robin search: first pending bit strictly after rr, wrapping back to rr itself.
    always_comb begin
        found  = 1'b0;
        winner = rr;
        for (int i = 1; i <= NCH; i++) begin
            if (!found && pending[rr + CW'(i)]) begin
                found  = 1'b1;
                winner = rr + CW'(i);
            end
        end
    end

    always_comb begin
        state_nx = state;
        grant    = 1'b0;
        take     = 1'b0;
        expire   = 1'b0;
        push     = 1'b0;
        case (state)
            IDLE: if (enable_i && found && count != FULL) begin
                grant    = 1'b1;
                state_nx = REQ;
            end
            REQ: if (m_ack_i) begin
                take     = 1'b1;
                state_nx = PUSH;
            end else if (tcnt == TW'(TIMEOUT - 1)) begin
                expire   = 1'b1;
                state_nx = PUSH;
            end
            PUSH: begin
                push     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
        if (clear_i) begin
            state_nx = IDLE;
            grant    = 1'b0;
            take     = 1'b0;
            expire   = 1'b0;
            push     = 1'b0;
        end
    end

    assign grant_mask = grant ? (NCH'(1) << winner) : '0;

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) state <= IDLE;
        else            state <= state_nx;
    end

    // Capture and arbitration state; a same-cycle rise re-arms the bit being granted.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            cmp_q      <= '0;
            pending    <= '0;
            overflow_o <= 1'b0;
            rr         <= CW'(NCH - 1);
            ts         <= '0;
        end else begin
            cmp_q <= cmp_i;
            if (clear_i) begin
                pending    <= '0;
                overflow_o <= 1'b0;
                ts         <= '0;
            end else begin
                pending <= (pending & ~grant_mask) | (enable_i ? rise : '0);
                if (enable_i && |(rise & pending & ~grant_mask)) overflow_o <= 1'b1;
                if (grant)    rr <= winner;
                if (ce_pcm_i) ts <= ts + 1'b1;
            end
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            m_valid_o <= '0;
            m_adr_o   <= '0;
            busy_o    <= 1'b0;
            tcnt      <= '0;
            to_flag   <= 1'b0;
            ts_lat    <= '0;
            ch_lat    <= '0;
            dat_lat   <= '0;
        end else if (clear_i) begin
            m_valid_o <= '0;
            m_adr_o   <= '0;
            busy_o    <= 1'b0;
        end else begin
            if (grant) begin
                m_valid_o <= NCH'(1) << winner;
                m_adr_o   <= rd_adr_i;
                busy_o    <= 1'b1;
                tcnt      <= '0;
                ch_lat    <= 4'(winner);
            end else if (take || expire) begin
                m_valid_o <= '0;
                m_adr_o   <= '0;
                to_flag   <= expire;
                dat_lat   <= take ? 16'(m_dat_i) : 16'h0;
                ts_lat    <= ts;
            end else if (state == REQ) begin
                tcnt <= tcnt + 1'b1;
            end
            if (push) busy_o <= 1'b0;
        end
    end

    // Event FIFO; space was reserved at grant so a push never meets a full queue.
    assign pop = evt_pop_i && (count != '0) && !clear_i;

    always_ff @(posedge wb_clk_i) begin
        if (push) mem[wr_ptr] <= {to_flag, ts_lat, ch_lat, dat_lat};
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign evt_valid_o = (count != '0);
    assign evt_data_o  = evt_valid_o ? mem[rd_ptr] : 32'h0;
    assign evt_count_o = 4'(count);
    assign irq_o       = evt_valid_o;
    assign m_strb_o    = 1'b0;

endmodule

// File: tb/tb_sonar_event_scheduler.sv
// Bench for sonar_event_scheduler: directed scenarios with literal expectations, then
// random traffic compared every cycle against a queue-based event model.
module tb_sonar_event_scheduler;
    localparam int TMO = 15;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        enable_i = 1'b0, clear_i = 1'b0, ce_pcm_i = 1'b0;
    logic [15:0] cmp_i = '0;
    logic [3:0]  rd_adr_i = '0;
    logic [15:0] m_valid_o;
    logic [3:0]  m_adr_o;
    logic        m_strb_o;
    logic        m_ack_i = 1'b0;
    logic [15:0] m_dat_i = '0;
    logic        busy_o, evt_pop_i = 1'b0, evt_valid_o;
    logic [31:0] evt_data_o;
    logic [3:0]  evt_count_o;
    logic        overflow_o, irq_o;

    int checks = 0, passes = 0;
    int ack_mode = 0;
    logic [15:0] chan_dat [16];

    sonar_event_scheduler #(.NCH(16), .DW(16), .DEPTH(8), .TIMEOUT(TMO)) dut (
        .wb_clk_i(clk), .wb_rst_ni(rst_n), .enable_i(enable_i), .clear_i(clear_i),
        .ce_pcm_i(ce_pcm_i), .cmp_i(cmp_i), .rd_adr_i(rd_adr_i), .m_valid_o(m_valid_o),
        .m_adr_o(m_adr_o), .m_strb_o(m_strb_o), .m_ack_i(m_ack_i), .m_dat_i(m_dat_i),
        .busy_o(busy_o), .evt_pop_i(evt_pop_i), .evt_valid_o(evt_valid_o),
        .evt_data_o(evt_data_o), .evt_count_o(evt_count_o), .overflow_o(overflow_o),
        .irq_o(irq_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    endtask

    // ---------------- behavioural model ----------------
    logic [15:0] md_cmpq = '0, md_pend = '0;
    logic        md_ovf = 1'b0;
    logic [10:0] md_ts = '0;
    int          md_rr = 15;
    logic [31:0] md_fifo [$];
    bit          md_req = 0, md_push = 0;
    logic [3:0]  md_ch = '0, md_adr = '0;
    int          md_wait = 0;
    logic [31:0] md_word = '0;

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            md_cmpq = '0; md_pend = '0; md_ovf = 0; md_ts = '0; md_rr = 15;
            md_fifo.delete(); md_req = 0; md_push = 0; md_wait = 0;
        end else if (clear_i) begin
            md_cmpq = cmp_i; md_pend = '0; md_ovf = 0; md_ts = '0;
            md_fifo.delete(); md_req = 0; md_push = 0;
        end else begin
            logic [15:0] rise, gm;
            int size0;
            rise  = cmp_i & ~md_cmpq;
            gm    = '0;
            size0 = md_fifo.size();
            if (evt_pop_i && size0 > 0) void'(md_fifo.pop_front());
            if (md_push) begin
                md_fifo.push_back(md_word);
                md_push = 0;
            end else if (md_req) begin
                if (m_ack_i) begin
                    md_word = {1'b0, md_ts, md_ch, m_dat_i};
                    md_req = 0; md_push = 1;
                end else if (md_wait == TMO - 1) begin
                    md_word = {1'b1, md_ts, md_ch, 16'h0};
                    md_req = 0; md_push = 1;
                end else md_wait++;
            end else if (enable_i && md_pend != 0 && size0 < 8) begin
                for (int k = 1; k <= 16; k++) begin
                    if (md_pend[(md_rr + k) % 16]) begin
                        md_rr = (md_rr + k) % 16;
                        break;
                    end
                end
                md_ch = 4'(md_rr); md_adr = rd_adr_i; md_wait = 0; md_req = 1;
                gm = 16'(1) << md_rr;
            end
            if (enable_i && (rise & md_pend & ~gm) != 0) md_ovf = 1;
            md_pend = (md_pend & ~gm) | (enable_i ? rise : 16'h0);
            if (ce_pcm_i) md_ts = md_ts + 11'd1;
            md_cmpq = cmp_i;
        end
    end

    // every-cycle comparison against the model
    initial forever begin
        @(negedge clk);
        chk("m_valid", 32'(m_valid_o), md_req ? 32'(16'(1) << md_ch) : 32'h0);
        chk("m_adr", 32'(m_adr_o), md_req ? 32'(md_adr) : 32'h0);
        chk("m_strb", 32'(m_strb_o), 32'h0);
        chk("busy", 32'(busy_o), 32'(md_req | md_push));
        chk("evt_valid", 32'(evt_valid_o), 32'(md_fifo.size() > 0));
        chk("irq", 32'(irq_o), 32'(md_fifo.size() > 0));
        chk("evt_count", 32'(evt_count_o), 32'(md_fifo.size()));
        chk("evt_data", evt_data_o, md_fifo.size() > 0 ? md_fifo[0] : 32'h0);
        chk("overflow", 32'(overflow_o), 32'(md_ovf));
    end

    // channel responder
    initial forever begin
        @(negedge clk);
        if (m_valid_o != 0) begin
            int idx;
            idx = 0;
            for (int k = 0; k < 16; k++) if (m_valid_o[k]) idx = k;
            m_dat_i = chan_dat[idx];
            case (ack_mode)
                0:       m_ack_i = 1'b1;
                1:       m_ack_i = ($urandom_range(0, 2) == 0);
                default: m_ack_i = 1'b0;
            endcase
        end else begin
            m_ack_i = 1'b0;
            m_dat_i = 16'h0;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin @(negedge clk); #1; end
    endtask

    task automatic do_reset();
        cmp_i = '0; clear_i = 0; evt_pop_i = 0; ce_pcm_i = 0;
        rst_n = 0;
        tick(2);
        rst_n = 1;
        tick(1);
    endtask

    task automatic pop_one();
        evt_pop_i = 1; tick(1); evt_pop_i = 0;
    endtask

    task automatic wait_grant(input string name);
        int n;
        n = 0;
        while (m_valid_o == 0 && n < 20) begin tick(1); n++; end
        chk(name, 32'(m_valid_o != 0), 32'h1);
    endtask

    task automatic single_event(input int ch);
        cmp_i[ch] = 1; tick(1); cmp_i[ch] = 0; tick(6);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int n;
        for (int k = 0; k < 16; k++) chan_dat[k] = 16'($urandom);
        chan_dat[5] = 16'h1234;
        tick(3);
        rst_n = 1; tick(1);
        chk("reset_valid", 32'(m_valid_o), 32'h0);
        chk("reset_count", 32'(evt_count_o), 32'h0);
        chk("reset_busy", 32'(busy_o), 32'h0);
        chk("reset_irq", 32'(irq_o), 32'h0);

        // 1: single event on ch5
        enable_i = 1; rd_adr_i = 4'd3; ack_mode = 0;
        cmp_i[5] = 1;
        tick(2);
        chk("t1_valid", 32'(m_valid_o), 32'h0020);
        chk("t1_adr", 32'(m_adr_o), 32'h3);
        tick(2);
        chk("t1_data", evt_data_o, 32'h0005_1234);
        chk("t1_count", 32'(evt_count_o), 32'h1);
        chk("t1_irq", 32'(irq_o), 32'h1);

        // 2: round-robin order with rr = 15, then rr = 2
        do_reset();
        cmp_i = 16'h0204; tick(10);
        chk("t2a_count", 32'(evt_count_o), 32'h2);
        chk("t2a_first", 32'(evt_data_o[19:16]), 32'd2);
        pop_one();
        chk("t2a_second", 32'(evt_data_o[19:16]), 32'd9);
        pop_one();
        cmp_i = '0; tick(1);
        single_event(2); pop_one();
        cmp_i = 16'h0204; tick(10);
        chk("t2b_first", 32'(evt_data_o[19:16]), 32'd9);
        pop_one();
        chk("t2b_second", 32'(evt_data_o[19:16]), 32'd2);
        pop_one();

        // 3: channel never acks
        do_reset();
        ack_mode = 2;
        cmp_i[7] = 1;
        wait_grant("t3_grant");
        n = 0;
        while (m_valid_o != 0 && n < 40) begin tick(1); n++; end
        chk("t3_valid_cycles", 32'(n), 32'd15);
        tick(1);
        chk("t3_busy", 32'(busy_o), 32'h0);
        chk("t3_flag", 32'(evt_data_o[31]), 32'h1);
        chk("t3_data", 32'(evt_data_o[15:0]), 32'h0);
        chk("t3_ch", 32'(evt_data_o[19:16]), 32'd7);

        // 4: full FIFO holds pending, overflow on coalesced rise
        do_reset();
        ack_mode = 0;
        for (int k = 1; k <= 8; k++) single_event(k);
        chk("t4_full", 32'(evt_count_o), 32'd8);
        cmp_i[0] = 1; tick(5);
        chk("t4_no_grant", 32'(m_valid_o), 32'h0);
        cmp_i[0] = 0; tick(1); cmp_i[0] = 1; tick(1);
        chk("t4_overflow", 32'(overflow_o), 32'h1);
        pop_one(); tick(1);
        chk("t4_serviced", 32'(m_valid_o), 32'h0001);
        tick(4);
        chk("t4_refull", 32'(evt_count_o), 32'd8);

        // 5: push and pop in the same cycle at count 4
        clear_i = 1; tick(1); clear_i = 0;
        chk("t5_cleared", 32'(evt_count_o), 32'h0);
        cmp_i = '0; tick(1);
        for (int k = 1; k <= 4; k++) single_event(k);
        chk("t5_count4", 32'(evt_count_o), 32'd4);
        cmp_i[6] = 1;
        n = 0;
        while (!(busy_o && m_valid_o == 0) && n < 20) begin tick(1); n++; end
        chk("t5_push_phase", 32'(busy_o && m_valid_o == 0), 32'h1);
        pop_one();
        chk("t5_count", 32'(evt_count_o), 32'd4);
        chk("t5_head", 32'(evt_data_o[19:16]), 32'd2);

        // 6a: clear during REQ
        ack_mode = 2;
        cmp_i = '0; tick(1);
        clear_i = 1; tick(1); clear_i = 0;
        cmp_i[3] = 1;
        wait_grant("t6a_grant");
        cmp_i[4] = 1; tick(1); cmp_i[4] = 0; tick(1); cmp_i[4] = 1; tick(1);
        chk("t6a_ovf_set", 32'(overflow_o), 32'h1);
        clear_i = 1; tick(1); clear_i = 0;
        chk("t6a_valid", 32'(m_valid_o), 32'h0);
        chk("t6a_busy", 32'(busy_o), 32'h0);
        chk("t6a_ovf", 32'(overflow_o), 32'h0);
        tick(20);
        chk("t6a_no_push", 32'(evt_count_o), 32'h0);

        // 6b: async reset during REQ
        cmp_i = '0; tick(1);
        cmp_i[3] = 1;
        wait_grant("t6b_grant");
        tick(2); #2;
        rst_n = 0; #1;
        chk("t6b_valid", 32'(m_valid_o), 32'h0);
        chk("t6b_busy", 32'(busy_o), 32'h0);
        chk("t6b_count", 32'(evt_count_o), 32'h0);
        tick(2); rst_n = 1; tick(1);

        // random traffic
        ack_mode = 0;
        for (int c = 0; c < 4000; c++) begin
            if (c % 250 == 0) begin
                n = int'($urandom % 8);
                ack_mode = (n == 0) ? 2 : (n < 4) ? 0 : 1;
            end
            cmp_i     ^= 16'($urandom) & 16'($urandom) & 16'($urandom) & 16'($urandom) & 16'($urandom);
            ce_pcm_i  = ($urandom % 4 != 0);
            enable_i  = ($urandom % 16 != 0);
            evt_pop_i = ($urandom % 4 == 0);
            rd_adr_i  = 4'($urandom);
            clear_i   = ($urandom % 500 == 0);
            tick(1);
        end
        clear_i = 0; evt_pop_i = 0;
        tick(2);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
